// File: rtl/binary_clock.sv
// Binary-coded-decimal 24-hour clock with a 1 Hz prescaler and debounced
// push-buttons for setting minutes and hours.
module binary_clock #(
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       inc_minute,
    input  logic       inc_hour,
    output logic       tick_1Hz,
    output logic       end_of_day,
    output logic [3:0] h_10s,
    output logic [3:0] h_1s,
    output logic [3:0] m_10s,
    output logic [3:0] m_1s,
    output logic [3:0] s_10s,
    output logic [3:0] s_1s
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          second_edge;

    logic [1:0]    raw;
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    fill;
    logic [1:0]    armed;
    logic [1:0]    stable;
    logic [1:0]    prev;
    logic [1:0]    inc_pulse;
    logic [DW-1:0] deb_cnt [2];

    logic [7:0] hour, minute, second;
    logic [7:0] hour_next, minute_next, second_next;
    logic       sec_wrap;
    logic       hour_carry;

    // Digit pairs are kept in BCD as {tens, ones} so the outputs come straight off flops.
    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            inc60 = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else
            inc60 = {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        if (v == 8'h23)
            inc24 = 8'h00;
        else if (v[3:0] == 4'd9)
            inc24 = {v[7:4] + 4'd1, 4'd0};
        else
            inc24 = {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign second_edge = (presc == PRESC_MAX);
    assign presc_next  = second_edge ? '0 : presc + PW'(1);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            tick_1Hz <= 1'b0;
        end else begin
            presc <= presc_next;
            if (second_edge)
                tick_1Hz <= 1'b1;
            else if (presc_next == PRESC_HALF)
                tick_1Hz <= 1'b0;
        end
    end

    assign raw = {inc_hour, inc_minute};

    // Until a button has been seen released for a full debounce window it stays
    // unarmed, so a button held through reset cannot produce an increment.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync_a     <= '0;
            sync_b     <= '0;
            fill       <= '0;
            armed      <= '0;
            stable     <= '0;
            prev       <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            fill   <= {fill[0], 1'b1};
            prev   <= stable;
            for (int i = 0; i < 2; i++) begin
                if (!fill[1]) begin
                    deb_cnt[i] <= '0;
                end else if (!armed[i]) begin
                    if (sync_b[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == DEB_MAX) begin
                        armed[i]   <= 1'b1;
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else if (sync_b[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    stable[i]  <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign inc_pulse = stable & ~prev;

    // A button pulse and a carry landing together advance a field only once.
    always_comb begin
        sec_wrap    = second_edge && (second == 8'h59);
        hour_carry  = sec_wrap && (minute == 8'h59);
        second_next = second_edge ? inc60(second) : second;
        minute_next = (sec_wrap || inc_pulse[0]) ? inc60(minute) : minute;
        hour_next   = (hour_carry || inc_pulse[1]) ? inc24(hour) : hour;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            hour       <= 8'h12;
            minute     <= 8'h00;
            second     <= 8'h00;
            end_of_day <= 1'b0;
        end else begin
            hour       <= hour_next;
            minute     <= minute_next;
            second     <= second_next;
            end_of_day <= ({hour_next, minute_next, second_next} == 24'h235959);
        end
    end

    assign h_10s = hour[7:4];
    assign h_1s  = hour[3:0];
    assign m_10s = minute[7:4];
    assign m_1s  = minute[3:0];
    assign s_10s = second[7:4];
    assign s_1s  = second[3:0];

endmodule

// File: tb/tb_binary_clock.sv
// Directed bench for binary_clock at CLK_HZ=10, DEBOUNCE_CYCLES=4; time is
// tracked by counting clock edges since reset release.
module tb_binary_clock;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       inc_minute = 1'b0;
    logic       inc_hour   = 1'b0;
    logic       tick_1Hz;
    logic       end_of_day;
    logic [3:0] h_10s, h_1s, m_10s, m_1s, s_10s, s_1s;
    logic [23:0] hms;

    int passed = 0;
    int total  = 0;
    int cyc;

    binary_clock #(
        .CLK_HZ(10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .inc_minute(inc_minute),
        .inc_hour(inc_hour),
        .tick_1Hz(tick_1Hz),
        .end_of_day(end_of_day),
        .h_10s(h_10s),
        .h_1s(h_1s),
        .m_10s(m_10s),
        .m_1s(m_1s),
        .s_10s(s_10s),
        .s_1s(s_1s)
    );

    assign hms = {h_10s, h_1s, m_10s, m_1s, s_10s, s_1s};

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got cyc=%0d expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk_100MHz);
    endtask

    task automatic do_reset();
        @(negedge clk_100MHz);
        reset = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
    endtask

    // Starts right after a second edge; the increment lands well before the next one.
    task automatic press_slot(input logic m, input logic h);
        inc_minute = m;
        inc_hour   = h;
        repeat (6) @(negedge clk_100MHz);
        inc_minute = 1'b0;
        inc_hour   = 1'b0;
        repeat (14) @(negedge clk_100MHz);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_100MHz);
        total++; if (hms !== 24'h120000) $display("FAIL reset_time: got %h expected %h", hms, 24'h120000); else passed++;
        total++; if (tick_1Hz !== 1'b0) $display("FAIL reset_tick: got %b expected 0", tick_1Hz); else passed++;
        total++; if (end_of_day !== 1'b0) $display("FAIL reset_eod: got %b expected 0", end_of_day); else passed++;
    endtask

    task automatic test_first_second();
        @(negedge clk_100MHz);
        reset = 1'b0;
        wait_until(9);
        total++; if (tick_1Hz !== 1'b0) $display("FAIL tick_before_edge: got %b expected 0", tick_1Hz); else passed++;
        total++; if (hms !== 24'h120000) $display("FAIL time_before_edge: got %h expected %h", hms, 24'h120000); else passed++;
        wait_until(10);
        total++; if (tick_1Hz !== 1'b1) $display("FAIL tick_rise: got %b expected 1", tick_1Hz); else passed++;
        total++; if (hms !== 24'h120001) $display("FAIL first_second: got %h expected %h", hms, 24'h120001); else passed++;
        wait_until(14);
        total++; if (tick_1Hz !== 1'b1) $display("FAIL tick_high_time: got %b expected 1", tick_1Hz); else passed++;
        wait_until(15);
        total++; if (tick_1Hz !== 1'b0) $display("FAIL tick_fall: got %b expected 0", tick_1Hz); else passed++;
        wait_until(20);
        total++; if (hms !== 24'h120002) $display("FAIL second_two: got %h expected %h", hms, 24'h120002); else passed++;
    endtask

    task automatic test_debounce();
        inc_minute = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        inc_minute = 1'b0;
        wait_until(40);
        total++; if (hms !== 24'h120004) $display("FAIL short_glitch: got %h expected %h", hms, 24'h120004); else passed++;
        inc_minute = 1'b1;
        repeat (20) @(negedge clk_100MHz);
        total++; if (hms !== 24'h120106) $display("FAIL held_once: got %h expected %h", hms, 24'h120106); else passed++;
        inc_minute = 1'b0;
        wait_until(80);
        total++; if (hms !== 24'h120108) $display("FAIL no_repeat: got %h expected %h", hms, 24'h120108); else passed++;
    endtask

    task automatic test_held_through_reset();
        @(negedge clk_100MHz);
        reset      = 1'b1;
        inc_minute = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        wait_until(40);
        total++; if (hms !== 24'h120004) $display("FAIL held_reset_hold: got %h expected %h", hms, 24'h120004); else passed++;
        inc_minute = 1'b0;
        wait_until(60);
        total++; if (hms !== 24'h120006) $display("FAIL held_reset_release: got %h expected %h", hms, 24'h120006); else passed++;
        press_slot(1'b1, 1'b0);
        total++; if (hms !== 24'h120108) $display("FAIL held_reset_repress: got %h expected %h", hms, 24'h120108); else passed++;
    endtask

    task automatic test_end_of_day();
        do_reset();
        wait_until(10);
        for (int j = 0; j < 58; j++) press_slot(1'b1, j < 11);
        total++; if (hms !== 24'h235957) $display("FAIL preset_eod: got %h expected %h", hms, 24'h235957); else passed++;
        wait_until(1180);
        total++; if (hms !== 24'h235958) $display("FAIL eod_time_58: got %h expected %h", hms, 24'h235958); else passed++;
        wait_until(1189);
        total++; if (end_of_day !== 1'b0) $display("FAIL eod_early: got %b expected 0", end_of_day); else passed++;
        wait_until(1190);
        total++; if (hms !== 24'h235959) $display("FAIL eod_time_59: got %h expected %h", hms, 24'h235959); else passed++;
        total++; if (end_of_day !== 1'b1) $display("FAIL eod_rise: got %b expected 1", end_of_day); else passed++;
        for (int n = 1191; n < 1200; n++) begin
            wait_until(n);
            total++; if (end_of_day !== 1'b1) $display("FAIL eod_hold cyc %0d: got %b expected 1", n, end_of_day); else passed++;
        end
        wait_until(1200);
        total++; if (hms !== 24'h000000) $display("FAIL midnight: got %h expected %h", hms, 24'h000000); else passed++;
        total++; if (end_of_day !== 1'b0) $display("FAIL eod_fall: got %b expected 0", end_of_day); else passed++;
        total++; if (tick_1Hz !== 1'b1) $display("FAIL midnight_tick: got %b expected 1", tick_1Hz); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        wait_until(10);
        for (int j = 0; j < 58; j++) press_slot(1'b1, 1'b0);
        wait_until(1190);
        total++; if (hms !== 24'h125959) $display("FAIL preset_carry: got %h expected %h", hms, 24'h125959); else passed++;
        wait_until(1193);
        inc_minute = 1'b1;
        repeat (6) @(negedge clk_100MHz);
        inc_minute = 1'b0;
        total++; if (hms !== 24'h125959) $display("FAIL carry_pre: got %h expected %h", hms, 24'h125959); else passed++;
        wait_until(1200);
        total++; if (hms !== 24'h130000) $display("FAIL carry_coincide: got %h expected %h", hms, 24'h130000); else passed++;
        wait_until(1210);
        total++; if (hms !== 24'h130001) $display("FAIL carry_after: got %h expected %h", hms, 24'h130001); else passed++;
    endtask

    task automatic test_hour_wrap_and_reset();
        do_reset();
        wait_until(10);
        for (int j = 0; j < 14; j++) press_slot(1'b1, j < 11);
        inc_minute = 1'b1;
        repeat (6) @(negedge clk_100MHz);
        inc_minute = 1'b0;
        wait_until(300);
        total++; if (hms !== 24'h231530) $display("FAIL preset_hour: got %h expected %h", hms, 24'h231530); else passed++;
        inc_hour = 1'b1;
        repeat (6) @(negedge clk_100MHz);
        inc_hour = 1'b0;
        wait_until(308);
        total++; if (hms !== 24'h001530) $display("FAIL hour_wrap: got %h expected %h", hms, 24'h001530); else passed++;
        total++; if (end_of_day !== 1'b0) $display("FAIL hour_wrap_eod: got %b expected 0", end_of_day); else passed++;
        wait_until(312);
        total++; if (tick_1Hz !== 1'b1) $display("FAIL mid_tick: got %b expected 1", tick_1Hz); else passed++;
        reset = 1'b1;
        #1;
        total++; if (hms !== 24'h120000) $display("FAIL async_reset_time: got %h expected %h", hms, 24'h120000); else passed++;
        total++; if (tick_1Hz !== 1'b0) $display("FAIL async_reset_tick: got %b expected 0", tick_1Hz); else passed++;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
        wait_until(9);
        total++; if (tick_1Hz !== 1'b0) $display("FAIL rerelease_early: got %b expected 0", tick_1Hz); else passed++;
        wait_until(10);
        total++; if (tick_1Hz !== 1'b1) $display("FAIL rerelease_tick: got %b expected 1", tick_1Hz); else passed++;
        total++; if (hms !== 24'h120001) $display("FAIL rerelease_time: got %h expected %h", hms, 24'h120001); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_second();
        test_debounce();
        test_held_through_reset();
        test_end_of_day();
        test_back_to_back();
        test_hour_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/binary_clock.md
BINARY_CLOCK -- requirements
Module: binary_clock

Interface
REQ-001 Parameter CLK_HZ, default 100000000, is the input clock cycles per second of time.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable cycles required to accept a button level.
REQ-003 clk_100MHz  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inc_minute  input  1  raw push-button, asynchronous to clk_100MHz, active-high.
REQ-006 inc_hour  input  1  raw push-button, asynchronous to clk_100MHz, active-high.
REQ-007 tick_1Hz  output  1  registered square wave, period CLK_HZ cycles; the calendar stage uses its rising edge.
REQ-008 end_of_day  output  1  registered; high while time is 23:59:59.
REQ-009 h_10s, h_1s, m_10s, m_1s, s_10s, s_1s  output  4 each  BCD hour, minute and second digits, registered.

Function
REQ-010 The prescaler shall count 0..CLK_HZ-1 and wrap to 0; the wrap cycle is the "second edge".
REQ-011 tick_1Hz shall be set on the second edge and cleared on the cycle the prescaler reaches CLK_HZ/2 (integer division), giving high time CLK_HZ/2 cycles.
REQ-012 On the second edge, seconds shall increment; 59 wraps to 0 and carries into minutes; minute 59 with carry wraps to 0 and carries into hours; hour 23 with carry wraps to 0.
REQ-013 Time registers and tick_1Hz shall update on the same clk_100MHz edge, so that end_of_day is high at each tick_1Hz rising edge whose time transition is 23:59:59 -> 00:00:00.
REQ-014 end_of_day shall be high exactly for the time value 23:59:59, for CLK_HZ cycles, and low otherwise.
REQ-015 Each button path shall be a 2-flop synchronizer followed by a debouncer: the debounced level changes only after the synchronized input has held a new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 A rising edge of the debounced level shall produce exactly one single-cycle increment pulse; holding the button shall not auto-repeat.
REQ-017 An inc_minute pulse shall add 1 to minutes modulo 60 without carry into hours; seconds shall be unchanged except by REQ-012.
REQ-018 An inc_hour pulse shall add 1 to hours modulo 24; minutes and seconds shall be unchanged except by REQ-012.
REQ-019 Button increments shall not clear the prescaler and shall not themselves generate end_of_day; end_of_day follows the resulting time per REQ-014.
REQ-020 If an inc_minute pulse coincides with a second edge carrying into minutes, minutes shall advance by exactly 1, and the carry into hours shall occur only if the prior minute value was 59.
REQ-021 The same single-advance rule shall apply to an inc_hour pulse coinciding with a minute-to-hour carry, with hour 23 wrapping to 0.
REQ-022 BCD outputs shall be the tens and ones digits of the binary fields; tens digits never exceed 5 for minutes and seconds or 2 for hours.

Reset
REQ-023 While reset is high: prescaler=0, tick_1Hz=0, end_of_day=0, time=12:00:00, synchronizer, debouncer and edge-detect state cleared to 0.
REQ-024 Reset assertion mid-second or mid-debounce shall abort it; after release the first second edge occurs after exactly CLK_HZ cycles.
REQ-025 A button held through reset release shall not generate an increment until it is released and pressed again.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-026 Release reset, run 10 cycles -> tick_1Hz rises on cycle 10, time 12:00:01; tick_1Hz falls 5 cycles later.
REQ-027 Preset 23:59:58 via buttons, run 2 seconds -> end_of_day high for the full 23:59:59 second and high at the rising tick where time becomes 00:00:00, then low.
REQ-028 inc_minute pulse shorter than 4 cycles -> no change; held 20 cycles -> minutes +1 exactly once.
REQ-029 Time xx:59:59 with inc_minute pulse aligned to the second edge -> minutes 59->00, hours +1, seconds 00.
REQ-030 inc_hour at 23:15:30 -> 00:15:30, end_of_day stays 0; reset asserted mid-second -> outputs 12:00:00, tick_1Hz 0 immediately.
